// File: rtl/icache_refill_ctrl_if.sv
// Refill controller bus bundle: fetch miss handshake, memory line-read port and data-SRAM write port.
// master = refill controller, slave = surrounding fetch/memory/SRAM environment.
interface icache_refill_ctrl_if #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned IDX_W = 6
);
  logic              miss_valid;
  logic [XLEN-1:0]   miss_addr;
  logic              miss_ready;
  logic              flush;

  logic              mem_req_valid;
  logic              mem_req_ready;
  logic [XLEN-1:0]   mem_req_addr;
  logic              mem_resp_valid;
  logic [63:0]       mem_resp_data;

  logic              sram_csb;
  logic              sram_web;
  logic [1:0]        sram_wmask;
  logic [IDX_W-1:0]  sram_addr;
  logic [127:0]      sram_din;

  logic              refill_busy;
  logic              refill_done;

  modport master (
    input  miss_valid, miss_addr, flush, mem_req_ready, mem_resp_valid, mem_resp_data,
    output miss_ready, mem_req_valid, mem_req_addr,
    output sram_csb, sram_web, sram_wmask, sram_addr, sram_din,
    output refill_busy, refill_done
  );

  modport slave (
    output miss_valid, miss_addr, flush, mem_req_ready, mem_resp_valid, mem_resp_data,
    input  miss_ready, mem_req_valid, mem_req_addr,
    input  sram_csb, sram_web, sram_wmask, sram_addr, sram_din,
    input  refill_busy, refill_done
  );
endinterface

// File: rtl/icache_refill_ctrl.sv
// Instruction-cache line refill: accepts a miss, fetches a 128-bit line as two 64-bit beats
// and writes each half into the data SRAM; a flush drains the outstanding beats without writing.
module icache_refill_ctrl #(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned IDX_W  = 6,
  parameter int unsigned OFFS_W = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  icache_refill_ctrl_if.master  bus
);

  localparam logic [XLEN-1:0] LINE_MASK = {{(XLEN-OFFS_W){1'b1}}, {OFFS_W{1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_BEAT0,
    S_BEAT1,
    S_DRAIN
  } state_e;

  state_e             state_q, state_d;
  logic [XLEN-1:0]    line_addr_q, line_addr_d;
  logic [1:0]         beat_cnt_q, beat_cnt_d;
  logic               req_valid_q, req_valid_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               csb_q, csb_d;
  logic               web_q, web_d;
  logic [1:0]         wmask_q, wmask_d;
  logic [IDX_W-1:0]   sram_addr_q, sram_addr_d;
  logic [127:0]       din_q, din_d;

  assign bus.miss_ready    = (state_q == S_IDLE) && !bus.flush;
  assign bus.mem_req_valid = req_valid_q;
  assign bus.mem_req_addr  = line_addr_q;
  assign bus.refill_busy   = busy_q;
  assign bus.refill_done   = done_q;
  assign bus.sram_csb      = csb_q;
  assign bus.sram_web      = web_q;
  assign bus.sram_wmask    = wmask_q;
  assign bus.sram_addr     = sram_addr_q;
  assign bus.sram_din      = din_q;

  // State and registered outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      line_addr_q <= '0;
      beat_cnt_q  <= '0;
      req_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      csb_q       <= 1'b1;
      web_q       <= 1'b1;
      wmask_q     <= 2'b00;
      sram_addr_q <= '0;
      din_q       <= '0;
    end else begin
      state_q     <= state_d;
      line_addr_q <= line_addr_d;
      beat_cnt_q  <= beat_cnt_d;
      req_valid_q <= req_valid_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      csb_q       <= csb_d;
      web_q       <= web_d;
      wmask_q     <= wmask_d;
      sram_addr_q <= sram_addr_d;
      din_q       <= din_d;
    end
  end

  // Next state and next registered outputs; writes are one-cycle strobes, data/index hold
  always_comb begin
    state_d     = state_q;
    line_addr_d = line_addr_q;
    beat_cnt_d  = beat_cnt_q;
    sram_addr_d = sram_addr_q;
    din_d       = din_q;
    csb_d       = 1'b1;
    web_d       = 1'b1;
    wmask_d     = 2'b00;
    done_d      = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (bus.miss_valid && !bus.flush) begin
          state_d     = S_REQ;
          line_addr_d = bus.miss_addr & LINE_MASK;
          sram_addr_d = bus.miss_addr[OFFS_W+IDX_W-1:OFFS_W];
          beat_cnt_d  = 2'd0;
        end
      end
      S_REQ: begin
        beat_cnt_d = 2'd0;
        if (bus.flush) begin
          // A flush coinciding with the handshake still owes two beats
          state_d = bus.mem_req_ready ? S_DRAIN : S_IDLE;
        end else if (bus.mem_req_ready) begin
          state_d = S_BEAT0;
        end
      end
      S_BEAT0: begin
        if (bus.flush) begin
          state_d    = S_DRAIN;
          beat_cnt_d = bus.mem_resp_valid ? 2'd1 : 2'd0;
        end else if (bus.mem_resp_valid) begin
          state_d    = S_BEAT1;
          beat_cnt_d = 2'd1;
          csb_d      = 1'b0;
          web_d      = 1'b0;
          wmask_d    = 2'b01;
          din_d      = {bus.mem_resp_data, bus.mem_resp_data};
        end
      end
      S_BEAT1: begin
        if (bus.flush) begin
          // Last beat arriving with the flush leaves nothing to drain
          state_d    = bus.mem_resp_valid ? S_IDLE : S_DRAIN;
          beat_cnt_d = bus.mem_resp_valid ? 2'd2 : 2'd1;
        end else if (bus.mem_resp_valid) begin
          state_d    = S_IDLE;
          beat_cnt_d = 2'd2;
          csb_d      = 1'b0;
          web_d      = 1'b0;
          wmask_d    = 2'b10;
          din_d      = {bus.mem_resp_data, bus.mem_resp_data};
          done_d     = 1'b1;
        end
      end
      S_DRAIN: begin
        if (bus.mem_resp_valid) begin
          beat_cnt_d = beat_cnt_q + 2'd1;
          if (beat_cnt_q != 2'd0) begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    req_valid_d = (state_d == S_REQ);
    busy_d      = (state_d != S_IDLE);
  end

endmodule

// File: tb/tb_icache_refill_ctrl.sv
// Bench for icache_refill_ctrl: directed scenarios then random traffic, each cycle compared
// against a transaction-level model of the refill (active / request pending / beats received).
module tb_icache_refill_ctrl;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned IDX_W  = 6;
  localparam int unsigned OFFS_W = 4;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  icache_refill_ctrl_if #(.XLEN(XLEN), .IDX_W(IDX_W)) bus ();

  icache_refill_ctrl #(.XLEN(XLEN), .IDX_W(IDX_W), .OFFS_W(OFFS_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_pass  = 0;
  int n_total = 0;

  // Reference model: refill in progress, request outstanding, beats seen, flushed
  bit          m_active;
  bit          m_req;
  int          m_got;
  bit          m_flushed;
  logic [31:0] m_line;
  logic [5:0]  m_idx;
  bit          m_wr;
  logic [1:0]  m_wmask;
  logic [127:0] m_din;
  bit          m_done;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic model_reset();
    m_active = 0; m_req = 0; m_got = 0; m_flushed = 0;
    m_wr = 0; m_done = 0; m_wmask = 2'b00; m_din = '0; m_idx = '0; m_line = '0;
  endtask

  task automatic model_step(input bit rst, input bit mv, input logic [31:0] ma, input bit fl,
                            input bit rdy, input bit rv, input logic [63:0] rd);
    if (rst) begin
      model_reset();
      return;
    end
    m_wr = 0;
    m_done = 0;
    m_wmask = 2'b00;
    if (!m_active) begin
      if (mv && !fl) begin
        m_active = 1; m_req = 1; m_got = 0; m_flushed = 0;
        m_line = ma & 32'hFFFF_FFF0;
        m_idx  = ma[9:4];
      end
    end else if (m_req) begin
      if (rdy) begin
        m_req = 0;
        if (fl) m_flushed = 1;
      end else if (fl) begin
        m_active = 0;
        m_req = 0;
      end
    end else begin
      if (rv) begin
        m_got++;
        if (!m_flushed && !fl) begin
          m_wr = 1;
          m_wmask = (m_got == 1) ? 2'b01 : 2'b10;
          m_din = {rd, rd};
          m_done = (m_got == 2);
        end
      end
      if (fl) m_flushed = 1;
      if (m_got == 2) m_active = 0;
    end
  endtask

  // One clock: drive inputs, compare outputs against model, advance model and DUT
  task automatic cyc(input bit rst, input bit mv, input logic [31:0] ma, input bit fl,
                     input bit rdy, input bit rv, input logic [63:0] rd, input bit do_chk);
    rst_n              = !rst;
    bus.miss_valid     = mv;
    bus.miss_addr      = ma;
    bus.flush          = fl;
    bus.mem_req_ready  = rdy;
    bus.mem_resp_valid = rv;
    bus.mem_resp_data  = rd;
    #1;
    if (do_chk) begin
      chk("miss_ready",    bus.miss_ready,    !m_active && !fl);
      chk("refill_busy",   bus.refill_busy,   m_active);
      chk("mem_req_valid", bus.mem_req_valid, m_active && m_req);
      if (m_active && m_req) chk("mem_req_addr", bus.mem_req_addr, m_line);
      chk("sram_csb",      bus.sram_csb,      !m_wr);
      chk("sram_web",      bus.sram_web,      !m_wr);
      chk("sram_wmask",    bus.sram_wmask,    m_wr ? m_wmask : 2'b00);
      chk("sram_addr",     bus.sram_addr,     m_idx);
      chk("sram_din",      bus.sram_din,      m_din);
      chk("refill_done",   bus.refill_done,   m_done);
    end
    model_step(rst, mv, ma, fl, rdy, rv, rd);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 32'h0, 0, 0, 0, 64'h0, 1);
  endtask

  localparam logic [63:0] BEAT_A = 64'hAAAA_AAAA_AAAA_AAAA;
  localparam logic [63:0] BEAT_B = 64'hBBBB_BBBB_BBBB_BBBB;

  initial begin
    model_reset();
    // Outputs are unknown until the first reset edge
    cyc(1, 0, 32'h0, 0, 0, 0, 64'h0, 0);
    cyc(1, 0, 32'h0, 0, 0, 0, 64'h0, 1);
    idle(2);
    chk("reset_csb", bus.sram_csb, 1'b1);
    chk("reset_busy", bus.refill_busy, 1'b0);

    // Basic refill of line 0x1230, index 0x23
    cyc(0, 1, 32'h0000_1230, 0, 0, 0, 64'h0, 1);
    chk("basic_req_addr", bus.mem_req_addr, 32'h0000_1230);
    cyc(0, 0, 32'h0, 0, 1, 0, 64'h0, 1);
    cyc(0, 0, 32'h0, 0, 0, 1, BEAT_A, 1);
    chk("basic_w0_mask", bus.sram_wmask, 2'b01);
    chk("basic_w0_idx", bus.sram_addr, 6'h23);
    cyc(0, 0, 32'h0, 0, 0, 1, BEAT_B, 1);
    chk("basic_w1_mask", bus.sram_wmask, 2'b10);
    chk("basic_w1_din", bus.sram_din, {BEAT_B, BEAT_B});
    chk("basic_done", bus.refill_done, 1'b1);
    idle(2);

    // Request backpressure for five cycles, then handshake and complete
    cyc(0, 1, 32'h0000_5678, 0, 0, 0, 64'h0, 1);
    for (int i = 0; i < 5; i++) cyc(0, 0, 32'h0, 0, 0, 0, 64'h0, 1);
    chk("bp_addr", bus.mem_req_addr, 32'h0000_5670);
    cyc(0, 0, 32'h0, 0, 1, 0, 64'h0, 1);
    cyc(0, 0, 32'h0, 0, 0, 1, 64'h1111, 1);
    cyc(0, 0, 32'h0, 0, 0, 0, 64'h0, 1);
    cyc(0, 0, 32'h0, 0, 0, 1, 64'h2222, 1);
    idle(2);

    // Flush one cycle after beat 0: first half still written, second beat drained
    cyc(0, 1, 32'h0000_0A40, 0, 0, 0, 64'h0, 1);
    cyc(0, 0, 32'h0, 0, 1, 0, 64'h0, 1);
    cyc(0, 0, 32'h0, 0, 0, 1, 64'h3333, 1);
    cyc(0, 0, 32'h0, 1, 0, 0, 64'h0, 1);
    cyc(0, 0, 32'h0, 0, 0, 0, 64'h0, 1);
    cyc(0, 0, 32'h0, 0, 0, 1, 64'h4444, 1);
    chk("flush_busy_end", bus.refill_busy, 1'b0);
    idle(2);

    // Flush in REQ with no handshake, then flush coinciding with handshake
    cyc(0, 1, 32'h0000_0100, 0, 0, 0, 64'h0, 1);
    cyc(0, 0, 32'h0, 1, 0, 0, 64'h0, 1);
    cyc(0, 0, 32'h0, 0, 0, 0, 64'h0, 1);
    cyc(0, 1, 32'h0000_0200, 0, 0, 0, 64'h0, 1);
    cyc(0, 0, 32'h0, 1, 1, 0, 64'h0, 1);
    cyc(0, 0, 32'h0, 0, 0, 1, 64'h5555, 1);
    cyc(0, 0, 32'h0, 0, 0, 1, 64'h6666, 1);
    idle(1);

    // Stray beat in IDLE with miss and flush together
    cyc(0, 1, 32'h0000_0300, 1, 0, 1, 64'h7777, 1);
    idle(2);

    // Reset during the second beat wait; later beat ignored
    cyc(0, 1, 32'h0000_0F70, 0, 0, 0, 64'h0, 1);
    cyc(0, 0, 32'h0, 0, 1, 0, 64'h0, 1);
    cyc(0, 0, 32'h0, 0, 0, 1, 64'h8888, 1);
    cyc(1, 0, 32'h0, 0, 0, 0, 64'h0, 1);
    cyc(0, 0, 32'h0, 0, 0, 1, 64'h9999, 1);
    chk("rst_idx", bus.sram_addr, 6'h00);
    idle(2);

    // Random traffic
    for (int i = 0; i < 4000; i++) begin
      cyc(($urandom_range(0, 199) == 0),
          $urandom_range(0, 1) == 1,
          $urandom(),
          ($urandom_range(0, 11) == 0),
          $urandom_range(0, 1) == 1,
          $urandom_range(0, 1) == 1,
          {$urandom(), $urandom()},
          1);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
